uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_uart_link.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_link.sv
// uart_link: UART transmitter with a small TX FIFO plus an independent
// receiver. Frames are start bit, DATA_BITS data bits (LSB first), an
// optional parity bit and STOP_BITS stop bits. The receiver checks only
// the first stop bit.
module uart_link #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 input_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 Tx,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam bit            HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    // Parity bit that accompanies a word: odd mode makes the total number
    // of ones odd, even mode makes it even.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_head;

    tx_state_t            tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_bit_done;

    assign fifo_empty  = (count == '0);
    assign tx_ready    = (count != FULL);
    assign fifo_push   = tx_valid && tx_ready && !reset;
    assign fifo_head   = fifo_mem[rd_ptr];
    assign tx_bit_done = (tx_cnt == BIT_LAST);
    assign tx_busy     = (tx_state != TX_IDLE) || !fifo_empty;

    // Pop the head word when the transmitter is ready for a new frame.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            if (tx_state == TX_IDLE)
                fifo_pop = 1'b1;
            else if (tx_state == TX_STOP && tx_bit_done && tx_bit == STOP_LAST)
                fifo_pop = 1'b1;
        end
    end

    // Storage array; the pointers define validity, so it carries no reset.
    // NOTE: memories are left unreset so they map onto plain RAM cells.
    always_ff @(posedge input_clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; a push and pop together keep the count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: Tx is registered and changes on the edge that enters a bit.
    // ------------------------------------------------------------------
    always_ff @(posedge input_clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            Tx       <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    Tx <= 1'b1;
                    if (fifo_pop) begin
                        tx_shift <= fifo_head;
                        tx_par   <= parity_of(fifo_head);
                        tx_cnt   <= '0;
                        Tx       <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_done) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        Tx       <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_done) begin
                        tx_cnt <= '0;
                        if (tx_bit == DATA_LAST) begin
                            tx_bit <= '0;
                            if (HAS_PARITY) begin
                                Tx       <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                Tx       <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                            Tx       <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_done) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        Tx       <= 1'b1;
                        tx_state <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_done) begin
                        tx_cnt <= '0;
                        if (tx_bit == STOP_LAST) begin
                            tx_bit <= '0;
                            if (fifo_pop) begin
                                // Next word queued: go straight to its start bit.
                                tx_shift <= fifo_head;
                                tx_par   <= parity_of(fifo_head);
                                Tx       <= 1'b0;
                                tx_state <= TX_START;
                            end else begin
                                Tx       <= 1'b1;
                                tx_state <= TX_IDLE;
                            end
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    Tx       <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    rx_state_t            rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;

    // Two-flop synchronizer for the asynchronous line, plus one more flop
    // of history for start-edge detection. All idle high.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX FSM: find the start edge, confirm it mid-bit, then sample each
    // later bit one bit period apart and report on the first stop bit.
    always_ff @(posedge input_clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        // A line already back high was a glitch, not a start bit.
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST)
                            rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        else
                            rx_bit <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_valid   <= 1'b1;
                        rx_data    <= rx_shift;
                        parity_err <= HAS_PARITY && (rx_par != parity_of(rx_shift));
                        frame_err  <= !rx_sync;
                        rx_state   <= rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // Hold off until the line is idle again (break or bad stop).
                    if (rx_sync)
                        rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: directed bench for uart_link with CLKS_PER_BIT=4,
// DATA_BITS=8, even parity, one stop bit and a 4-entry TX FIFO.
module tb_uart_link;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_line;
    logic       rx_drive;
    logic       loopback;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rx_line = loopback ? tx_line : rx_drive;

    uart_link #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .PARITY      (2),
        .STOP_BITS   (1),
        .FIFO_DEPTH  (4)
    ) dut (
        .input_clk (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .Tx        (tx_line),
        .Rx        (rx_line),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line bits in transmit order: start, data LSB first, even parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    // Check Tx over a whole frame, starting at the first start-bit cycle.
    task automatic expect_frame(input string tag, input logic [10:0] bits);
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check($sformatf("%s_bit%0d", tag, b), tx_line, bits[b]);
                tick();
            end
        end
    endtask

    task automatic wait_tx_low(input string tag, input int budget);
        int n;
        n = 0;
        while (tx_line !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, tx_line, 1'b0);
    endtask

    task automatic drive_bit(input logic b);
        rx_drive = b;
        repeat (CPB) tick();
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    logic [7:0] burst_w [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] loop_w  [3] = '{8'h00, 8'hFF, 8'h3C};
    logic [7:0] abort_w [3] = '{8'h96, 8'h3C, 8'hC3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_drive = 1'b1;
        loopback = 1'b0;

        // Reset state, with tx_valid offered during reset to show it is ignored.
        repeat (2) tick();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        repeat (2) tick();
        check("rst_tx",         tx_line,    1'b1);
        check("rst_tx_ready",   tx_ready,   1'b1);
        check("rst_tx_busy",    tx_busy,    1'b0);
        check("rst_rx_valid",   rx_valid,   1'b0);
        check("rst_rx_data",    rx_data,    8'h00);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err",  frame_err,  1'b0);
        tx_valid = 1'b0;
        reset    = 1'b0;
        tick();
        check("rst_valid_ignored", tx_busy, 1'b0);

        // Single word 0xA5 from idle.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("a5_tx_high_on_accept", tx_line, 1'b1);
        check("a5_busy_queued",       tx_busy, 1'b1);
        tick();
        expect_frame("a5", 11'b1_0_1010_0101_0);
        check("a5_busy_after", tx_busy, 1'b0);
        check("a5_tx_idle",    tx_line, 1'b1);

        // Six words offered back to back; FIFO fills, frames stay contiguous.
        fork
            begin
                int  n;
                logic was_ready;
                for (int i = 0; i < 6; i++) begin
                    tx_data  = burst_w[i];
                    tx_valid = 1'b1;
                    n = 0;
                    do begin
                        was_ready = tx_ready;
                        tick();
                        n++;
                    end while (!was_ready && n < 400);
                    if (i == 4) check("burst_full_after_4", tx_ready, 1'b0);
                    if (i == 5) check("burst_w5_waited", (n > 1), 1'b1);
                end
                tx_valid = 1'b0;
            end
            begin
                wait_tx_low("burst", 20);
                for (int k = 0; k < 6; k++)
                    expect_frame($sformatf("burst%0d", k), frame_of(burst_w[k]));
                check("burst_busy_after",  tx_busy,  1'b0);
                check("burst_ready_after", tx_ready, 1'b1);
            end
        join

        // Loopback of three words.
        loopback = 1'b1;
        tick();
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    tx_data  = loop_w[i];
                    tx_valid = 1'b1;
                    tick();
                end
                tx_valid = 1'b0;
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 200; c++) begin
                    if (rx_valid) begin
                        if (got < 3) begin
                            check($sformatf("loop%0d_data", got), rx_data, loop_w[got]);
                            check($sformatf("loop%0d_perr", got), parity_err, 1'b0);
                            check($sformatf("loop%0d_ferr", got), frame_err,  1'b0);
                        end
                        got++;
                    end
                    tick();
                end
                check("loop_frames", got, 3);
            end
        join
        loopback = 1'b0;
        tick();

        // 0x81 with wrong parity and low stop, line held low, then a good 0x5A.
        fork
            begin
                drive_frame(8'h81, 1'b1, 1'b0);
                repeat (6) drive_bit(1'b0);
                repeat (4) drive_bit(1'b1);
                drive_frame(8'h5A, 1'b0, 1'b1);
                repeat (4) drive_bit(1'b1);
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 150; c++) begin
                    if (rx_valid) begin
                        if (got == 0) begin
                            check("bad_data", rx_data,    8'h81);
                            check("bad_perr", parity_err, 1'b1);
                            check("bad_ferr", frame_err,  1'b1);
                        end else if (got == 1) begin
                            check("good_data", rx_data,    8'h5A);
                            check("good_perr", parity_err, 1'b0);
                            check("good_ferr", frame_err,  1'b0);
                        end
                        got++;
                    end
                    tick();
                end
                check("bad_then_good_frames", got, 2);
            end
        join

        // One-cycle low glitch on Rx.
        begin
            int got;
            got = 0;
            rx_drive = 1'b0;
            tick();
            rx_drive = 1'b1;
            for (int c = 0; c < 60; c++) begin
                if (rx_valid) got++;
                tick();
            end
            check("glitch_no_frame", got, 0);
            check("glitch_data_kept", rx_data, 8'h5A);
        end

        // Reset mid-frame during a 3-word burst in loopback.
        loopback = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tx_data  = abort_w[i];
            tx_valid = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        repeat (6) tick();
        check("abort_mid_data_bit0", tx_line, abort_w[0][0]);
        check("abort_busy_before",   tx_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_tx_high",  tx_line,  1'b1);
        check("abort_ready",    tx_ready, 1'b1);
        check("abort_busy",     tx_busy,  1'b0);
        check("abort_rx_data",  rx_data,  8'h00);
        begin
            int lows;
            int pulses;
            lows   = 0;
            pulses = 0;
            for (int c = 0; c < 80; c++) begin
                if (tx_line !== 1'b1) lows++;
                if (rx_valid) pulses++;
                tick();
            end
            check("abort_no_more_bits", lows,   0);
            check("abort_no_rx_pulse",  pulses, 0);
            check("abort_busy_end",     tx_busy, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
